// File: rtl/hd_pkg.sv
// Shared definitions for the HD handshake stage and its downstream elastic buffer.
package hd_pkg;

    localparam int unsigned HD_DATA_WIDTH_DEF = 16;

    typedef logic [HD_DATA_WIDTH_DEF-1:0] hd_word_t;

    // Pointer carries one extra wrap bit above the storage index.
    function automatic int unsigned hd_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hd_fifo_ptr.sv
// Wrap-bit pointer counter for hd_fifo; wraps modulo 2**PW (= 2*DEPTH).
module hd_fifo_ptr #(
    parameter int unsigned PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/hd_fifo.sv
// First-word-fall-through elastic buffer behind the HD stage.
// Define HD_FIFO_LEVEL_EN to add the registered occupancy output `level`.
module hd_fifo
    import hd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = HD_DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [DATA_WIDTH-1:0]         data_src,
    output logic                          ready_output,
    output logic                          valid_output,
    output logic [DATA_WIDTH-1:0]         data_dest,
    input  logic                          ready
`ifdef HD_FIFO_LEVEL_EN
    ,
    output logic [hd_ptr_w(DEPTH)-1:0]    level
`endif
);

    localparam int unsigned PW = hd_ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign empty = (wp == rp);
    assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);

    assign ready_output = rst && !full;
    assign valid_output = !empty;
    assign data_dest    = mem[rp[AW-1:0]];

    assign push = valid && ready_output;
    assign pop  = valid_output && ready;

    hd_fifo_ptr #(.PW(PW)) u_wp (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wp)
    );

    hd_fifo_ptr #(.PW(PW)) u_rp (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rp)
    );

    // Storage is cleared on reset so data_dest reads 0 while the buffer is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wp[AW-1:0]] <= data_src;
        end
    end

`ifdef HD_FIFO_LEVEL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (push && !pop) begin
            level <= level + PW'(1);
        end else if (pop && !push) begin
            level <= level - PW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hd_fifo.sv
// Randomised self-checking bench for hd_fifo against a queue-based reference model.
module tb_hd_fifo;
    import hd_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = hd_ptr_w(DEPTH);

    logic     clk = 1'b0;
    logic     rst;
    logic     valid;
    hd_word_t data_src;
    logic     ready_output;
    logic     valid_output;
    hd_word_t data_dest;
    logic     ready;
`ifdef HD_FIFO_LEVEL_EN
    logic [PW-1:0] level;
`endif

    int checks   = 0;
    int failures = 0;

    hd_word_t q[$];
    bit       in_reset;
    int       total_pushes = 0;

    always #5 clk = ~clk;

    hd_fifo #(.DATA_WIDTH(HD_DATA_WIDTH_DEF), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .data_src     (data_src),
        .ready_output (ready_output),
        .valid_output (valid_output),
        .data_dest    (data_dest),
        .ready        (ready)
`ifdef HD_FIFO_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("valid_output", {31'd0, valid_output}, {31'd0, (q.size() != 0)});
        check("ready_output", {31'd0, ready_output},
              {31'd0, (!in_reset && q.size() < DEPTH)});
        if (in_reset)
            check("data_dest_rst", {16'd0, data_dest}, 32'd0);
        else if (q.size() != 0)
            check("data_dest", {16'd0, data_dest}, {16'd0, q[0]});
`ifdef HD_FIFO_LEVEL_EN
        check("level", 32'(level), 32'(q.size()));
`endif
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model at the rising edge.
    task automatic cycle(input logic v, input hd_word_t d, input logic r, output bit accepted);
        bit do_push, do_pop;
        @(negedge clk);
        check_model();
        valid    = v;
        data_src = d;
        ready    = r;
        do_push  = v && !in_reset && (q.size() < DEPTH);
        do_pop   = r && !in_reset && (q.size() != 0);
        @(posedge clk);
        if (do_pop)  void'(q.pop_front());
        if (do_push) begin
            q.push_back(d);
            total_pushes++;
        end
        accepted = do_push;
    endtask

    initial begin
        bit       acc;
        hd_word_t n;
        bit       cur_v;
        hd_word_t cur_d;

        rst = 1'b0; valid = 1'b0; data_src = '0; ready = 1'b0;
        in_reset = 1'b1;

        // Reset then idle
        repeat (2) cycle(1'b0, '0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; in_reset = 1'b0;
        #1 check("rel_ready", {31'd0, ready_output}, 32'd1);
        repeat (2) cycle(1'b0, '0, 1'b0, acc);

        // Fill to full, then offer a fifth word that must be refused
        for (int i = 1; i <= 4; i++) cycle(1'b1, hd_word_t'(i), 1'b0, acc);
        #1;
        check("full_ready", {31'd0, ready_output}, 32'd0);
        check("full_head", {16'd0, data_dest}, 32'd1);
`ifdef HD_FIFO_LEVEL_EN
        check("full_level", 32'(level), 32'd4);
`endif
        cycle(1'b1, 16'd5, 1'b0, acc);
        check("fifth_refused", {31'd0, acc}, 32'd0);

        // Drain from full
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, acc);
        check("drained", {31'd0, valid_output}, 32'd0);

        // Streaming with both sides ready
        for (int i = 1; i <= 20; i++) cycle(1'b1, hd_word_t'(i), 1'b1, acc);
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, acc);

        // Wrap-around with ready toggling, producer holding until accepted
        n = 16'd1;
        for (int i = 0; i < 200 && n <= 12; i++) begin
            cycle(1'b1, n, (i % 2) == 0, acc);
            if (acc) n++;
        end
        check("wrap_all_pushed", 32'(n), 32'd13);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, acc);
        check("wrap_drained", {31'd0, valid_output}, 32'd0);

        // Random traffic honouring the producer hold contract
        cur_v = 1'b0; cur_d = '0;
        for (int i = 0; i < 300; i++) begin
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = hd_word_t'($urandom);
            end
            cycle(cur_v, cur_d, $urandom_range(0, 2) != 0, acc);
            if (acc) cur_v = 1'b0;
        end
        check("pointer_wrapped", {31'd0, (total_pushes > 2 * DEPTH)}, 32'd1);

        // Reset mid-operation with three words stored
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) cycle(1'b1, hd_word_t'(16'h0100 + i), 1'b0, acc);
        #3;
        rst = 1'b0; in_reset = 1'b1;
        q.delete();
        #1;
        check("midrst_valid", {31'd0, valid_output}, 32'd0);
        check("midrst_ready", {31'd0, ready_output}, 32'd0);
        check("midrst_data", {16'd0, data_dest}, 32'd0);
`ifdef HD_FIFO_LEVEL_EN
        check("midrst_level", 32'(level), 32'd0);
`endif
        repeat (2) cycle(1'b0, '0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; in_reset = 1'b0;
        cycle(1'b1, 16'h00AA, 1'b0, acc);
        #1;
        check("rst_first_valid", {31'd0, valid_output}, 32'd1);
        check("rst_first_word", {16'd0, data_dest}, 32'h00AA);
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b0, '0, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hd_fifo.md
# hd_fifo

Elastic buffer placed directly downstream of the `HD` handshake stage. It absorbs the words `HD` emits on its valid/ready output and re-presents them, in order, to the next consumer. This decouples `HD` from consumer stalls of up to `DEPTH` words. Valid/ready semantics are identical on both sides: a transfer occurs on a rising `clk` edge when valid and ready are both high.

## Interface
- `DATA_WIDTH`, 16, payload width in bits
- `DEPTH`, 4, storage entries; power of two, ≥ 2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = in reset)
- `valid`  in  1  upstream word available (driven by `HD` `valid_output`)
- `data_src`  in  `DATA_WIDTH`  upstream word (driven by `HD` `data_dest`)
- `ready_output`  out  1  FIFO can accept a word this cycle (drives `HD` `ready`)
- `valid_output`  out  1  FIFO holds at least one word
- `data_dest`  out  `DATA_WIDTH`  oldest stored word
- `ready`  in  1  downstream consumer accepts `data_dest`
- `level`  out  `$clog2(DEPTH)+1`  occupancy, 0..`DEPTH` (present only with `HD_FIFO_LEVEL_EN`)

## Operation
- Storage: `DEPTH`-entry register array. Write pointer `wp` and read pointer `rp` are each `$clog2(DEPTH)+1` bits wide; the MSB is the wrap bit.
- Empty: `wp == rp`. Full: low bits equal and wrap bits differ.
- Push: `valid && ready_output`. Writes `data_src` to `mem[wp]`, then `wp` increments modulo 2·`DEPTH`.
- Pop: `valid_output && ready`. `rp` increments modulo 2·`DEPTH`.
- `ready_output` = `rst && !full`.
- `valid_output` = `!empty`.
- `data_dest` = `mem[rp]`. This is a first-word-fall-through read directly from the register array.
- Push and pop in the same cycle: both pointers advance and occupancy is unchanged. This is legal at any occupancy in 1..`DEPTH`-1.
- When full, push is blocked because `ready_output`=0. A pop is still allowed; `ready_output` rises the cycle after it.
- When empty, pop is blocked because `valid_output`=0. A word pushed into an empty FIFO is never forwarded combinationally; it appears the next cycle.
- `data_dest` is held stable while `valid_output && !ready`.
- Reset (async assert, any time, including mid-burst):
  - `wp`, `rp` ← 0 and all `mem` entries ← 0.
  - Outputs: `valid_output`=0, `ready_output`=0, `data_dest`=0, `level`=0.
  - Stored words are discarded.
  - Release is sampled synchronously. `ready_output` becomes 1 in the first cycle after deassertion.
- Once a producer raises `valid`, it holds `valid` and `data_src` until the transfer. This is the `HD` contract; the FIFO does not check it.

## Timing
- Write-to-read latency: 1 cycle. A word pushed at edge N is visible on `data_dest` with `valid_output`=1 after edge N.
- Throughput: 1 word/cycle sustained when both sides are ready.
- Full → not full: `ready_output` rises 1 cycle after the popping edge.
- Empty → not empty: `valid_output` rises 1 cycle after the pushing edge.
- No combinational path from `ready` to `ready_output`, or from `valid` to `valid_output`.
- All outputs derive from registers only, apart from `rst` gating of `ready_output`.

## Configuration
- `HD_FIFO_LEVEL_EN` defined: the `level` output port exists.
  - `level` is a registered occupancy counter: +1 on push-only, −1 on pop-only, unchanged on both or neither.
  - `level` equals `wp − rp` at all times.
- `HD_FIFO_LEVEL_EN` undefined: the `level` port and its counter are omitted. All other behaviour is identical.

## Structure
- Shared package `hd_pkg`:
  - `HD_DATA_WIDTH_DEF` = 16.
  - Pointer-width helper `hd_ptr_w(depth)` = `$clog2(depth)+1`.
  - `hd_word_t` typedef.
- One sub-module, `hd_fifo_ptr`: a wrap-bit pointer counter.
  - Inputs: `clk`, `rst`, `inc`. Output: `ptr`.
  - Instantiated twice, once for `wp` and once for `rp`.
- Full/empty compare, storage and output muxing live in `hd_fifo`.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles, then 1. Required: `valid_output`=0, `data_dest`=0, `ready_output`=0 during reset and 1 the cycle after release, `level`=0.
- Fill with `DEPTH`=4: `ready`=0, push 1,2,3,4 on consecutive cycles. Required: `ready_output`=0 after the 4th push, `level`=4, `data_dest`=1; a 5th `valid` word is not accepted.
- Drain from full: `ready`=1 with `valid`=0. Required: `data_dest` shows 1,2,3,4 on successive cycles, then `valid_output`=0; `ready_output`=1 one cycle after the first pop.
- Streaming: `valid`=`ready`=1 for 20 cycles with `data_src` incrementing from 1. Required: output sequence 1..20 in order with one cycle of latency; `level` stays at 1.
- Wrap-around with random stalls: toggle `ready` as 1,0,1,0 while pushing 1..12. Required: `data_dest` returns 1..12 in order with no loss or duplication; the pointer wrap bit flips at least once.
- Reset mid-operation: 3 words stored, assert `rst` asynchronously mid-cycle. Required: `valid_output` and `level` drop to 0 immediately; after release the next pushed value, 0x00AA, is the first word out.
